// File: rtl/thermo_ramp_ctrl.sv
// Slew-limited level sequencer with thermometer-coded output.
// Steps toward a requested level, settles, then pulses done.
module thermo_ramp_ctrl #(
  parameter int N        = 8,
  parameter int MAX_STEP = 4,
  parameter int HOLD     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [N-1:0]      din,
  output logic              din_ready,
  output logic [2**N-1:0]   dout,
  output logic [N-1:0]      level,
  output logic              busy,
  output logic              done
);

  localparam logic [N-1:0] LP_STEP  = N'(MAX_STEP);
  localparam logic [7:0]   LP_HOLD1 = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_SETTLE
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_level;
  logic [N-1:0] w_level_nxt;
  logic [N-1:0] r_target;
  logic [N-1:0] w_target_nxt;
  logic [7:0]   r_cnt;
  logic [7:0]   w_cnt_nxt;
  logic         r_done;
  logic         w_done_nxt;

  logic         w_up;
  logic [N-1:0] w_diff;
  logic [N-1:0] w_step;
  logic [2**N-1:0] w_dout;

  // Step size: distance after the magnitude compare, clamped to MAX_STEP.
  always_comb begin
    w_up   = r_target > r_level;
    w_diff = w_up ? (r_target - r_level) : (r_level - r_target);
    w_step = (w_diff > LP_STEP) ? LP_STEP : w_diff;
  end

  // Next-state and next-datapath values for the sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (din_valid) begin
          w_target_nxt = din;
          if (din != r_level) begin
            w_state_nxt = S_RAMP;
          end else begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = LP_HOLD1;
          end
        end
      end
      S_RAMP: begin
        w_level_nxt = w_up ? (r_level + w_step) : (r_level - w_step);
        if (w_level_nxt == r_target) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = LP_HOLD1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Level, target, settle counter and done pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level  <= '0;
      r_target <= '0;
      r_cnt    <= 8'd0;
      r_done   <= 1'b0;
    end else begin
      r_level  <= w_level_nxt;
      r_target <= w_target_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Thermometer decode: level k lights bits [k:0].
  always_comb begin
    w_dout = '0;
    for (int i = 0; i < 2**N; i++) begin
      w_dout[i] = (i <= int'(r_level));
    end
  end

  assign dout      = w_dout;
  assign level     = r_level;
  assign din_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_thermo_ramp_ctrl.sv
// Self-checking bench for thermo_ramp_ctrl.
// Expected per-cycle outputs are queued at request time.
module tb_thermo_ramp_ctrl;

  localparam int N    = 8;
  localparam int STEP = 4;
  localparam int HLD  = 2;

  logic           clk;
  logic           reset;
  logic           din_valid;
  logic [N-1:0]   din;
  logic           din_ready;
  logic [255:0]   dout;
  logic [N-1:0]   level;
  logic           busy;
  logic           done;

  int n_tests;
  int n_fail;
  int cur_lvl;

  typedef struct {
    int   lvl;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  exp_t sb[$];

  thermo_ramp_ctrl #(
    .N(N),
    .MAX_STEP(STEP),
    .HOLD(HLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din_valid(din_valid),
    .din(din),
    .din_ready(din_ready),
    .dout(dout),
    .level(level),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] therm(int l);
    logic [255:0] v;
    for (int i = 0; i < 256; i++) v[i] = (i <= l);
    return v;
  endfunction

  // Expected trajectory for one request, one entry per cycle after
  // accept edge A+k, k = 0 .. R+HOLD (the last is the done cycle).
  task automatic push_traj(input int from, input int to);
    int d;
    int r;
    int mv;
    exp_t e;
    d = (to > from) ? to - from : from - to;
    r = (d + STEP - 1) / STEP;
    for (int k = 0; k <= r + HLD; k++) begin
      mv = (k * STEP > d) ? d : k * STEP;
      e.lvl  = (to > from) ? from + mv : from - mv;
      e.busy = (k < r + HLD);
      e.done = (k == r + HLD);
      e.rdy  = (k == r + HLD);
      sb.push_back(e);
    end
  endtask

  // Present a request, then pop and compare each cycle until done.
  task automatic serve(input int t, input bit keep, input bit scram,
                       input string nm);
    exp_t e;
    din       = N'(t);
    din_valid = 1'b1;
    push_traj(cur_lvl, t);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (!keep) din_valid = 1'b0;
      if (scram) din = N'($urandom_range(0, 255));
      n_tests++;
      if (int'(level) !== e.lvl) begin
        n_fail++;
        $display("FAIL %s level got %0d want %0d", nm, level, e.lvl);
      end
      n_tests++;
      if (dout !== therm(e.lvl)) begin
        n_fail++;
        $display("FAIL %s dout got %h want %h", nm, dout, therm(e.lvl));
      end
      n_tests++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s busy got %b want %b", nm, busy, e.busy);
      end
      n_tests++;
      if (done !== e.done) begin
        n_fail++;
        $display("FAIL %s done got %b want %b", nm, done, e.done);
      end
      n_tests++;
      if (din_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL %s ready got %b want %b", nm, din_ready, e.rdy);
      end
    end
    cur_lvl = t;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (level !== 8'd0 || dout !== 256'd1) begin
        n_fail++;
        $display("FAIL reset level got %0d dout %h want 0 / 1",
                 level, dout);
      end
      n_tests++;
      if (din_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset rdy/busy/done got %b%b%b want 100",
                 din_ready, busy, done);
      end
    end
    cur_lvl = 0;
  endtask

  task automatic test_up_ramp();
    serve(10, 1'b0, 1'b0, "up");
    n_tests++;
    if (dout !== 256'h7FF) begin
      n_fail++;
      $display("FAIL up_dout got %h want 7ff", dout);
    end
  endtask

  task automatic test_down_ramp();
    serve(1, 1'b0, 1'b0, "down");
    n_tests++;
    if (dout !== 256'h3) begin
      n_fail++;
      $display("FAIL down_dout got %h want 3", dout);
    end
  endtask

  task automatic test_same_value();
    serve(1, 1'b0, 1'b0, "same");
  endtask

  task automatic test_back_to_back();
    serve(0, 1'b0, 1'b0, "to0");
    serve(255, 1'b1, 1'b1, "full_up");
    n_tests++;
    if (dout !== {256{1'b1}}) begin
      n_fail++;
      $display("FAIL full_dout got %h want all ones", dout);
    end
    serve(0, 1'b0, 1'b0, "b2b_down");
  endtask

  task automatic test_reset_mid_ramp();
    din       = 8'd20;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (level !== 8'd8 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midramp_pre level got %0d busy %b want 8 1",
               level, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (level !== 8'd0 || dout !== 256'd1) begin
      n_fail++;
      $display("FAIL midramp_async level got %0d dout %h want 0 / 1",
               level, dout);
    end
    n_tests++;
    if (busy !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midramp_state busy %b ready %b want 0 1",
               busy, din_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || level !== 8'd0) begin
        n_fail++;
        $display("FAIL post_reset done %b busy %b level %0d want 0 0 0",
                 done, busy, level);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cur_lvl = 0;
    reset   = 1'b1;
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_same_value();
    test_back_to_back();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/thermo_ramp_ctrl.md
# thermo_ramp_ctrl

Slew-limited sequencer for the thermometer-coded level datapath. It accepts a target binary level over a valid/ready handshake and steps an internal level register toward that target by at most MAX_STEP codes per cycle. After arrival it holds for a fixed settle window, then pulses `done`. It continuously drives the thermometer code of the current level, so a thermometer-coded DAC or segment array never sees a full-scale jump in one cycle.

## Interface
- `N`, default 8: level width; thermometer output is 2**N bits.
- `MAX_STEP`, default 4: maximum level change per cycle, legal range 1 .. 2**N-1.
- `HOLD`, default 2: settle cycles after the target is reached, legal range 1 .. 255.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `din_valid`  in  1  target request valid.
- `din`  in  N  target level (binary).
- `din_ready`  out  1  block can accept a target.
- `dout`  out  2**N  thermometer code of current level: level k drives bits [k:0] high, all others low.
- `level`  out  N  current level (binary).
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse marking the end of the settle window.

## Operation
- Clock and reset: one clock domain, `clk`. Reset is asynchronous and active-high, on `reset`.
- States are IDLE, RAMP and SETTLE. Registers are state, `level`, target, settle counter (8 bits) and `done`.
- `din_ready` is 1 only in IDLE. `busy` is 1 in RAMP and SETTLE.
- Accept: a request is accepted on a rising edge where `din_valid` and `din_ready` are both high. On accept, target is set to `din`.
  - If `din` differs from `level`, the next state is RAMP.
  - If `din` equals `level`, the next state is SETTLE with the counter loaded to HOLD-1.
- `din_valid` and `din` are ignored outside IDLE. No queuing.
- RAMP, every cycle:
  - diff = |target - level|, computed after the magnitude compare, so no wrap.
  - If target > level, `level` increases by min(MAX_STEP, diff). If target < level, `level` decreases by min(MAX_STEP, diff).
  - On the edge where `level` becomes equal to target, the next state is SETTLE and the counter is loaded to HOLD-1.
  - `level` never overshoots the target and never wraps past 0 or 2**N-1.
- SETTLE: the counter decrements each cycle. On the edge where the counter is 0, the next state is IDLE and `done` is set to 1 for exactly one cycle.
- `dout` and `level` are combinational functions of the level register, so `dout` always matches `level`.
- Reset values:
  - state IDLE, `level` 0, so `dout` = 1 (only bit 0 high).
  - target 0, counter 0.
  - `done` 0, `busy` 0, `din_ready` 1.
- Reset asserted mid-operation (RAMP or SETTLE): the block returns to the reset values immediately. No `done` is produced for the aborted request.

## Timing
- Let A be the accept edge and R = ceil(|din - level_at_accept| / MAX_STEP).
- The first level change is visible after edge A+1. The last level change is visible after edge A+R.
- SETTLE occupies the HOLD cycles that follow. `done` is high during the cycle after edge A+R+HOLD; when R = 0, this is the cycle after edge A+HOLD.
- The `done` cycle is an IDLE cycle with `din_ready` = 1. A new request may be accepted in that same cycle; back-to-back service has no gap cycle.
- `din_ready` drops during the cycle after edge A. `busy` rises during that same cycle.

## Test plan
- Reset, then hold `din_valid` low for 3 cycles.
  - Required: `level` = 0, `dout` = 1, `din_ready` = 1, `busy` = 0, `done` never asserted.
- Up ramp from level 0 to `din` = 10 (MAX_STEP = 4, HOLD = 2).
  - Required: `level` reads 4, 8, 10 after A+1, A+2, A+3.
  - `dout` = 0x7FF from A+3.
  - `done` is high only in the cycle after A+5.
- Down ramp from 10 to `din` = 1.
  - Required: `level` reads 6, 2, 1.
  - `dout` = 0x3 at the end.
  - `done` after A+5.
- Same-value request `din` = 1 while `level` = 1.
  - Required: no level change, `busy` high for 2 cycles, `done` after A+2.
- Full-scale 0 to 255, with `din_valid` held high and changing `din` during the ramp; then a new `din` = 0 presented in the `done` cycle.
  - Required: changes to `din` during the ramp are ignored.
  - 64 RAMP cycles, then `dout` is all ones.
  - The request presented in the `done` cycle is accepted in that cycle.
  - The level then ramps down by 4 per cycle.
- Assert `reset` mid-ramp at level 8 (target 20).
  - Required: `level` = 0 and `dout` = 1 immediately, before the next clock edge.
  - State IDLE, no `done` pulse afterward.
